// File: rtl/dmem_lsu.sv
// Load/store unit in front of a 32-bit byte-addressed dmem; sub-word stores use read-modify-write.
// Optional build macro DMEM_LSU_MISALIGN_TRAP_EN rejects misaligned halfword/word accesses.
module dmem_lsu #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              dm_r_w,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_MERGE, S_RESP} state_t;

  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rd_q, rd_d;
  logic                err_q, err_d;

  logic                req_undef;
  logic                req_misalign;
  logic [DATA_W-1:0]   load_ext;

  assign req_undef = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);

`ifdef DMEM_LSU_MISALIGN_TRAP_EN
  assign req_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                        ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  assign req_misalign = 1'b0;
`endif

  // funct3[2] selects zero extension, funct3[1:0] the access size
  always_comb begin
    case (funct3_q)
      3'b000:  load_ext = {{(DATA_W-8){rd_q[7]}}, rd_q[7:0]};
      3'b100:  load_ext = {{(DATA_W-8){1'b0}}, rd_q[7:0]};
      3'b001:  load_ext = {{(DATA_W-16){rd_q[15]}}, rd_q[15:0]};
      3'b101:  load_ext = {{(DATA_W-16){1'b0}}, rd_q[15:0]};
      default: load_ext = rd_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    funct3_d   = funct3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    err_d      = err_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    dm_r_w     = 1'b0;
    dm_addr    = addr_q;
    dm_wdata   = '0;

    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          rd_d     = '0;
          if (req_undef || req_misalign) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            err_d   = 1'b0;
            state_d = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        if (we_q && (funct3_q[1:0] == 2'b10)) begin
          dm_r_w   = 1'b1;
          dm_wdata = wdata_q;
          state_d  = S_RESP;
        end else if (we_q) begin
          rd_d    = dm_rdata;
          state_d = S_MERGE;
        end else begin
          rd_d    = dm_rdata;
          state_d = S_RESP;
        end
      end
      S_MERGE: begin
        // rd_q holds the old word; only the low byte/halfword is replaced
        dm_r_w   = 1'b1;
        dm_wdata = funct3_q[0] ? {rd_q[DATA_W-1:16], wdata_q[15:0]}
                               : {rd_q[DATA_W-1:8], wdata_q[7:0]};
        state_d  = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        if (!we_q && !err_q) begin
          resp_rdata = load_ext;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rd_q     <= rd_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu: directed requests push expectations, a monitor checks responses.
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        dm_r_w;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;

  always #5 clk = ~clk;

  dmem_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .dm_r_w     (dm_r_w),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_rdata   (dm_rdata)
  );

  // dmem model: 4 KiB, combinational read, 4-byte write at posedge
  logic [7:0]  mem [0:4095];
  logic        pl_en;
  logic [11:0] pl_addr;
  logic [31:0] pl_data;
  logic [11:0] wa;

  assign wa = dm_addr[11:0];
  assign dm_rdata = {mem[wa + 12'd3], mem[wa + 12'd2], mem[wa + 12'd1], mem[wa]};

  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_addr]         <= pl_data[7:0];
      mem[pl_addr + 12'd1] <= pl_data[15:8];
      mem[pl_addr + 12'd2] <= pl_data[23:16];
      mem[pl_addr + 12'd3] <= pl_data[31:24];
    end else if (dm_r_w) begin
      mem[wa]         <= dm_wdata[7:0];
      mem[wa + 12'd1] <= dm_wdata[15:8];
      mem[wa + 12'd2] <= dm_wdata[23:16];
      mem[wa + 12'd3] <= dm_wdata[31:24];
    end
  end

  function automatic logic [31:0] mem_word(input logic [11:0] a);
    return {mem[a + 12'd3], mem[a + 12'd2], mem[a + 12'd1], mem[a]};
  endfunction

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   wr_cnt   = 0;
  int   last_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Monitor: pops one expectation per response pulse
  always @(negedge clk) begin
    if (dm_r_w) wr_cnt++;
    if (resp_valid && !reset) begin
      if (sbq.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        $display("resp %s rdata=%h err=%b lat=%0d", e.name, resp_rdata, resp_err, cyc - e.acc + 1);
        chk({e.name, "_rdata"}, resp_rdata, e.rdata);
        chk({e.name, "_err"}, {31'd0, resp_err}, {31'd0, e.err});
        chk({e.name, "_lat"}, cyc - e.acc + 1, e.lat);
      end
    end
  end

  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Presents a request and waits for its accept edge; leaves req_valid high
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] erd, input logic eerr,
                       input int elat, input string nm);
    int n;
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk({nm, "_accept_timeout"}, 32'd0, 32'd1);
      req_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      last_acc = cyc;
      e.name = nm; e.rdata = erd; e.err = eerr; e.lat = elat; e.acc = cyc;
      sbq.push_back(e);
    end
  endtask

  task automatic drain(input string nm);
    int n;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (sbq.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      chk({nm, "_resp_timeout"}, 32'd0, 32'd1);
      sbq.delete();
    end
    @(negedge clk);
  endtask

  task automatic op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                    input logic [31:0] wd, input logic [31:0] erd, input logic eerr,
                    input int elat, input int ewr, input string nm);
    int w0;
    w0 = wr_cnt;
    issue(we, f3, a, wd, erd, eerr, elat, nm);
    drain(nm);
    chk({nm, "_writes"}, wr_cnt - w0, ewr);
  endtask

  initial begin
    repeat (5000) @(posedge clk);
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = '0; req_wdata = '0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;

    preload(12'h010, 32'h01020304);
    preload(12'h100, 32'h00000000);
    preload(12'h104, 32'h55667788);
    preload(12'h200, 32'h11223344);
    preload(12'h300, 32'hCAFEBABE);
    preload(12'h000, 32'h0A0B0C0D);
    preload(12'h004, 32'h70605040);
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_dm_r_w", {31'd0, dm_r_w}, 32'd0);
    chk("rst_dm_addr", dm_addr, 32'd0);
    chk("rst_dm_wdata", dm_wdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Reset in the middle of an SB read-modify-write
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h10; req_wdata = 32'h5A;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("rmw_merge_write_en", {31'd0, dm_r_w}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rmw_reset_dm_r_w", {31'd0, dm_r_w}, 32'd0);
    chk("rmw_reset_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rmw_reset_mem", mem_word(12'h010), 32'h01020304);
    chk("rmw_ready_after", {31'd0, req_ready}, 32'd1);

    op(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1, "sw_100");
    op(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0, "lw_100");

    op(1'b1, 3'b000, 32'h200, 32'h000000AA, 32'h0, 1'b0, 3, 1, "sb_200");
    chk("sb_200_mem", mem_word(12'h200), 32'h112233AA);
    op(1'b0, 3'b000, 32'h200, 32'h0, 32'hFFFFFFAA, 1'b0, 2, 0, "lb_200");
    op(1'b0, 3'b100, 32'h200, 32'h0, 32'h000000AA, 1'b0, 2, 0, "lbu_200");
    op(1'b0, 3'b000, 32'h201, 32'h0, 32'h00000033, 1'b0, 2, 0, "lb_201");

    op(1'b1, 3'b001, 32'h300, 32'h00008001, 32'h0, 1'b0, 3, 1, "sh_300");
    chk("sh_300_mem", mem_word(12'h300), 32'hCAFE8001);
    op(1'b0, 3'b001, 32'h300, 32'h0, 32'hFFFF8001, 1'b0, 2, 0, "lh_300");
    op(1'b0, 3'b101, 32'h300, 32'h0, 32'h00008001, 1'b0, 2, 0, "lhu_300");

    // Back-to-back with req_valid held high
    issue(1'b0, 3'b010, 32'h0, 32'h0, 32'h0A0B0C0D, 1'b0, 2, "lw_000");
    a1 = last_acc;
    issue(1'b0, 3'b010, 32'h4, 32'h0, 32'h70605040, 1'b0, 2, "lw_004");
    chk("b2b_accept_gap", last_acc - a1, 3);
    drain("b2b");

    op(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 1'b1, 1, 0, "ld_f3_011");
    op(1'b1, 3'b011, 32'h100, 32'h12345678, 32'h0, 1'b1, 1, 0, "st_f3_011");
    op(1'b1, 3'b111, 32'h100, 32'h12345678, 32'h0, 1'b1, 1, 0, "st_f3_111");
    chk("undef_store_mem", mem_word(12'h100), 32'hDEADBEEF);
`ifdef DMEM_LSU_MISALIGN_TRAP_EN
    op(1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 1'b1, 1, 0, "lw_102_trap");
    op(1'b1, 3'b001, 32'h301, 32'h0000BEEF, 32'h0, 1'b1, 1, 0, "sh_301_trap");
    chk("sh_301_trap_mem", mem_word(12'h300), 32'hCAFE8001);
`else
    op(1'b0, 3'b010, 32'h102, 32'h0, 32'h7788DEAD, 1'b0, 2, 0, "lw_102");
    op(1'b0, 3'b001, 32'h301, 32'h0, 32'hFFFFFE80, 1'b0, 2, 0, "lh_301");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
